ifetch_unit: RTL and testbench

//  Instruction fetch stage for the single-cycle MIPS datapath, directly upstream of the control decoder.

---
 rtl/ifetch_unit_if.sv | 32 +++
 rtl/ifetch_unit.sv | 124 ++++++++++++
 tb/tb_ifetch_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decoded-instruction hand-off
// to the control decoder, and the decoder/ALU feedback used to form the next PC.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        branch;
  logic        zero;
  logic        jump;

  logic [31:0] retired;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, instr_pc, retired,
    input  imem_ack, imem_rdata, instr_ready, branch, zero, jump
  );

  // Memory / decoder / execute side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, instr_pc, retired,
    output imem_ack, imem_rdata, instr_ready, branch, zero, jump
  );
endinterface

// File: rtl/ifetch_unit.sv
// MIPS fetch stage: PC register, req/ack fetch, hold instruction until retired, next-PC select.
// Latency: 2 cycles/instr minimum; memory wait states stretch FETCH, instr_ready low stretches HOLD.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master io_fetch
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_first;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_valid;
  logic [31:0] r_retired;

  logic        w_req;
  logic        w_accept;
  logic        w_retire;
  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request is held off for the first cycle after reset release.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_accept    = 1'b0;
    w_retire    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_req = !r_first;
        if (w_req && io_fetch.imem_ack) begin
          w_accept    = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (io_fetch.instr_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  assign w_pc4       = r_instr_pc + 32'd4;
  assign w_br_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_target = w_pc4 + w_br_off;
  assign w_j_target  = {w_pc4[31:28], r_instr[25:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc4;
    if (io_fetch.jump) begin
      w_next_pc = w_j_target;
    end else if (io_fetch.branch && io_fetch.zero) begin
      w_next_pc = w_br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first    <= 1'b1;
      r_pc       <= RESET_PC_ALIGNED;
      r_instr    <= 32'd0;
      r_instr_pc <= 32'd0;
      r_valid    <= 1'b0;
      r_retired  <= 32'd0;
    end else begin
      r_first <= 1'b0;
      if (w_accept) begin
        r_instr    <= io_fetch.imem_rdata;
        r_instr_pc <= r_pc;
        r_valid    <= 1'b1;
      end
      if (w_retire) begin
        r_pc      <= {w_next_pc[31:2], 2'b00};
        r_valid   <= 1'b0;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign io_fetch.imem_req    = w_req;
  assign io_fetch.imem_addr   = r_pc;
  assign io_fetch.instr_valid = r_valid;
  assign io_fetch.instr       = r_instr;
  assign io_fetch.op          = r_instr[31:26];
  assign io_fetch.instr_pc    = r_instr_pc;
  assign io_fetch.retired     = r_retired;

  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    r_pc[1:0] == 2'b00);

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (w_req && !io_fetch.imem_ack) |=> (w_req && $stable(r_pc)));

  a_valid_is_hold: assert property (@(posedge clk) disable iff (!rst_n)
    r_valid == (r_state == S_HOLD));

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized and directed bench for ifetch_unit against a transaction-level PC/instruction model.
module tb_ifetch_unit;

  logic clk;
  logic rst_n;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_fetch (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_ret;
  bit          m_hold;
  bit          m_first;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] ins, input logic [31:0] ipc,
                                           input bit b, input bit z, input bit j);
    logic [31:0] seq;
    int          off;
    seq = ipc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'(ins & 32'h0000_FFFF);
      if (off >= 32768) off = off - 65536;
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic drive_idle();
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.instr_ready = 1'b0;
    bus.branch      = 1'b0;
    bus.zero        = 1'b0;
    bus.jump        = 1'b0;
  endtask

  // Called at a negedge; asserts reset, checks cleared outputs, releases at the next negedge.
  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_req",     32'(bus.imem_req),    32'd0);
    chk("rst_valid",   32'(bus.instr_valid), 32'd0);
    chk("rst_instr",   bus.instr,            32'd0);
    chk("rst_op",      32'(bus.op),          32'd0);
    chk("rst_ipc",     bus.instr_pc,         32'd0);
    chk("rst_retired", bus.retired,          32'd0);
    chk("rst_addr",    bus.imem_addr,        32'h0000_3000);
    @(negedge clk);
    rst_n   = 1'b1;
    m_pc    = 32'h0000_3000;
    m_instr = 32'd0;
    m_ipc   = 32'd0;
    m_ret   = 32'd0;
    m_hold  = 1'b0;
    m_first = 1'b1;
  endtask

  // One cycle: check outputs at negedge, drive inputs, advance model, move to next negedge.
  task automatic step(input bit ack, input logic [31:0] rd, input bit rdy,
                      input bit b, input bit z, input bit j);
    chk("valid",   32'(bus.instr_valid), 32'(m_hold));
    chk("addr",    bus.imem_addr,        m_pc);
    chk("retired", bus.retired,          m_ret);
    if (m_hold) begin
      chk("req_hold", 32'(bus.imem_req), 32'd0);
      chk("instr",    bus.instr,         m_instr);
      chk("op",       32'(bus.op),       32'(m_instr[31:26]));
      chk("instr_pc", bus.instr_pc,      m_ipc);
    end else begin
      chk("req_fetch", 32'(bus.imem_req), 32'(!m_first));
    end

    bus.imem_ack    = ack;
    bus.imem_rdata  = rd;
    bus.instr_ready = rdy;
    bus.branch      = b;
    bus.zero        = z;
    bus.jump        = j;

    if (m_first) begin
      m_first = 1'b0;
    end else if (!m_hold) begin
      if (ack) begin
        m_hold  = 1'b1;
        m_instr = rd;
        m_ipc   = m_pc;
      end
    end else if (rdy) begin
      m_pc   = ref_next(m_instr, m_ipc, b, z, j);
      m_hold = 1'b0;
      m_ret  = m_ret + 32'd1;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  // Fetch one instruction with dly wait states, then retire it with the given b/z/j.
  task automatic run_instr(input logic [31:0] rd, input bit b, input bit z, input bit j,
                           input int dly, output logic [31:0] faddr);
    if (m_first) step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    faddr = bus.imem_addr;
    for (int d = 0; d < dly; d++) step(1'b0, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, rd, 1'b0, !b, !z, !j);
    chk("valid_after_ack", 32'(bus.instr_valid), 32'd1);
    step(1'b0, 32'd0, 1'b1, b, z, j);
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);

    // Sequential NOPs from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_instr(32'd0, 1'b0, 1'b0, 1'b0, 0, a);
      chk("seq_addr", a, 32'h0000_3000 + 32'(4 * i));
    end
    chk("retired3", bus.retired, 32'd3);

    // beq -1 taken / not taken at 0x3010
    run_instr(32'd0, 1'b0, 1'b0, 1'b0, 0, a);
    run_instr(32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 0, a);
    chk("beq_at", a, 32'h0000_3010);
    chk("beq_taken", bus.imem_addr, 32'h0000_3010);
    run_instr(32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 0, a);
    chk("beq_not_taken", bus.imem_addr, 32'h0000_3014);

    // Jump beats taken branch at 0x3020
    for (int i = 0; i < 3; i++) run_instr(32'd0, 1'b0, 1'b0, 1'b0, 0, a);
    run_instr(32'h0800_0C10, 1'b1, 1'b1, 1'b1, 0, a);
    chk("j_at", a, 32'h0000_3020);
    chk("jump_wins", bus.imem_addr, 32'h0000_3040);

    // Three-cycle ack delay
    run_instr(32'd0, 1'b0, 1'b0, 1'b0, 3, a);
    chk("delay_addr", a, 32'h0000_3040);
    chk("delay_next", bus.imem_addr, 32'h0000_3044);

    // Reset while holding the instruction at 0x3008
    do_reset();
    run_instr(32'd0, 1'b0, 1'b0, 1'b0, 0, a);
    run_instr(32'd0, 1'b0, 1'b0, 1'b0, 0, a);
    step(1'b1, 32'h2400_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_pc", bus.instr_pc, 32'h0000_3008);
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h0000_3000);
    chk("post_rst_retired", bus.retired, 32'd0);

    // Branch back to 0xFFFF_FFFC, then sequential wrap to 0
    run_instr(32'h1000_F3FE, 1'b1, 1'b1, 1'b0, 0, a);
    chk("to_top", bus.imem_addr, 32'hFFFF_FFFC);
    run_instr(32'd0, 1'b0, 1'b0, 1'b0, 0, a);
    chk("wrap_zero", bus.imem_addr, 32'h0000_0000);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_ack_ignored", bus.instr, 32'h1234_5678);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 2) != 0, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
